// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the EHXPLLL dynamic phase-shift sequencer.
// Purely declarative: no logic, no latency, no backpressure.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    STEP_HI   = 3'd2,
    STEP_LO   = 3'd3,
    LOCK_WAIT = 3'd4,
    DONE      = 3'd5
  } state_t;

  typedef logic [1:0] phasesel_t;

  localparam phasesel_t SEL_CLKOS  = 2'b00;
  localparam phasesel_t SEL_CLKOS2 = 2'b01;
  localparam phasesel_t SEL_CLKOS3 = 2'b10;
  localparam phasesel_t SEL_CLKOP  = 2'b11;

  localparam logic DIR_LAG  = 1'b0;
  localparam logic DIR_LEAD = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP with setup/high/hold timing, then waits for re-lock (optional PLL_PHASE_CTRL_STARTUP_EN).
// Latency: done one cycle after LOCK_WAIT, i.e. accept + SETUP_CYC + N*(HIGH_CYC+HOLD_CYC) + 1 edges; N=0 gives done right after accept.
// Backpressure: req_ready only in IDLE; a request offered while busy waits with the requester, nothing is queued.
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int        STEP_W        = 8,
  parameter int        SETUP_CYC     = 4,
  parameter int        HIGH_CYC      = 4,
  parameter int        HOLD_CYC      = 4,
  parameter int        LOCK_TIMEOUT  = 1024,
  parameter int        STARTUP_STEPS = 0,
  parameter logic [1:0] STARTUP_SEL  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              pll_locked,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_MAX = max2(max2(SETUP_CYC, HIGH_CYC), max2(HOLD_CYC, LOCK_TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef PLL_PHASE_CTRL_STARTUP_EN
  localparam logic START_EN = (STARTUP_STEPS != 0);
`else
  localparam logic START_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [STEP_W-1:0] rem, rem_nxt;
  phasesel_t         sel_nxt;
  logic              dir_nxt;
  logic              start_pend, start_pend_nxt;
  logic              to_err;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      start_pend <= START_EN;
      phasesel   <= SEL_CLKOP;
      phasedir   <= DIR_LAG;
      phasestep  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rem        <= rem_nxt;
      start_pend <= start_pend_nxt;
      phasesel   <= sel_nxt;
      phasedir   <= dir_nxt;
      // Outputs are decoded from the next state so they align with the state register.
      phasestep  <= (state_nxt == STEP_HI);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      err        <= to_err;
      req_ready  <= (state_nxt == IDLE) && !start_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    rem_nxt        = rem;
    sel_nxt        = phasesel;
    dir_nxt        = phasedir;
    start_pend_nxt = start_pend;
    to_err         = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_pend) begin
          sel_nxt        = STARTUP_SEL;
          dir_nxt        = DIR_LAG;
          rem_nxt        = STEP_W'(STARTUP_STEPS);
          start_pend_nxt = 1'b0;
          state_nxt      = SETUP;
        end else if (req_valid && req_ready) begin
          sel_nxt   = req_sel;
          dir_nxt   = req_dir;
          rem_nxt   = req_steps;
          state_nxt = (req_steps == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = STEP_HI;
        end
      end
      STEP_HI: begin
        if (cnt == CNT_W'(HIGH_CYC - 1)) begin
          cnt_nxt   = '0;
          rem_nxt   = rem - STEP_W'(1);
          state_nxt = STEP_LO;
        end
      end
      STEP_LO: begin
        // sel/dir are unchanged between steps, so further pulses skip SETUP.
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (rem != '0) ? STEP_HI : LOCK_WAIT;
        end
      end
      LOCK_WAIT: begin
        if (pll_locked) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_nxt   = '0;
          to_err    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
